conv2d_feeder: RTL

//  Stream source for the conv2D processing-element array. It is the producer end of the
//  pe_weight_* / pe_fm_* streams. Fetches a WT_DIM x WT_DIM weight tile, then a
//  fm_dim x fm_dim feature map, from memory over a request/response read port and

---
 rtl/conv2d_feeder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/conv2d_feeder.sv
// Conv2D feeder: fetches a weight tile, then a feature map, over a read port and streams
// both to the PE array, slotting feature-map words around the PEs' zero halo.
module conv2d_feeder #(
  parameter int unsigned AWIDTH     = 32,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned WT_DIM     = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] weight_base,
  input  logic [AWIDTH-1:0] fm_base,
  input  logic [DWIDTH-1:0] fm_dim,
  output logic              busy,
  output logic              done,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [AWIDTH-1:0] req_addr,
  input  logic              resp_valid,
  input  logic [DWIDTH-1:0] resp_data,
  output logic [DWIDTH-1:0] pe_weight_data_o,
  output logic              pe_weight_data_valid,
  output logic [DWIDTH-1:0] pe_fm_data_o,
  output logic              pe_fm_data_valid
);
  localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned WtWords = WT_DIM * WT_DIM;
  localparam int unsigned EmitW   = $clog2(WtWords + 1);

  typedef enum logic [1:0] {StIdle, StWeight, StFm, StDone} state_e;
  state_e state_q, state_d;

  logic [AWIDTH-1:0] addr_q, fm_base_q;
  logic [DWIDTH-1:0] dim_q, req_col_q, req_row_q, x_q, y_q;
  logic [CntW-1:0]   outst_q, fifo_cnt_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [EmitW-1:0]  wemit_q;
  logic [DWIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic              fetching, req_fire, resp_push, fifo_empty, credit_ok;
  logic              w_pop, fm_pop, fm_adv, pop, halo, last_slot, start_ok, enter_fm;
  logic [DWIDTH-1:0] req_lim, dim_p1;
  logic [CntW:0]     credit_used;

  assign fetching    = (state_q == StWeight) || (state_q == StFm);
  assign req_lim     = (state_q == StWeight) ? DWIDTH'(WT_DIM) : dim_q;
  // Cap counts words already buffered plus words still in flight, so the FIFO cannot overflow.
  assign credit_used = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
  assign credit_ok   = credit_used < (CntW + 1)'(FIFO_DEPTH);
  assign req_valid   = fetching && (req_row_q < req_lim) && credit_ok;
  assign req_addr    = addr_q;
  assign req_fire    = req_valid && req_ready;
  assign resp_push   = fetching && resp_valid;
  assign fifo_empty  = (fifo_cnt_q == '0);

  assign dim_p1    = dim_q + DWIDTH'(1);
  assign halo      = (x_q == '0) || (y_q == '0) || (x_q == dim_p1) || (y_q == dim_p1);
  assign last_slot = (x_q == dim_p1) && (y_q == dim_p1);
  assign w_pop     = (state_q == StWeight) && !fifo_empty && (wemit_q != EmitW'(WtWords));
  assign fm_pop    = (state_q == StFm) && !halo && !fifo_empty;
  assign fm_adv    = (state_q == StFm) && (halo || !fifo_empty);
  assign pop       = w_pop || fm_pop;
  assign start_ok  = (state_q == StIdle) && start;
  assign enter_fm  = (state_q == StWeight) && (state_d == StFm);

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StWeight;
      StWeight: if (wemit_q == EmitW'(WtWords)) state_d = StFm;
      StFm:     if (fm_adv && last_slot) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (resp_push) fifo_mem[wr_ptr_q] <= resp_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q               <= '0;
      fm_base_q            <= '0;
      dim_q                <= '0;
      req_col_q            <= '0;
      req_row_q            <= '0;
      x_q                  <= '0;
      y_q                  <= '0;
      outst_q              <= '0;
      fifo_cnt_q           <= '0;
      wr_ptr_q             <= '0;
      rd_ptr_q             <= '0;
      wemit_q              <= '0;
      pe_weight_data_o     <= '0;
      pe_weight_data_valid <= 1'b0;
      pe_fm_data_o         <= '0;
      pe_fm_data_valid     <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_q    <= weight_base;
        fm_base_q <= fm_base;
        dim_q     <= fm_dim;
        req_col_q <= '0;
        req_row_q <= '0;
        wemit_q   <= '0;
        x_q       <= '0;
        y_q       <= '0;
      end else if (enter_fm) begin
        addr_q    <= fm_base_q;
        req_col_q <= '0;
        req_row_q <= '0;
      end else if (req_fire) begin
        addr_q <= addr_q + AWIDTH'(4);
        if (req_col_q == req_lim - DWIDTH'(1)) begin
          req_col_q <= '0;
          req_row_q <= req_row_q + DWIDTH'(1);
        end else begin
          req_col_q <= req_col_q + DWIDTH'(1);
        end
      end

      if (w_pop) wemit_q <= wemit_q + EmitW'(1);

      if (fm_adv) begin
        if (x_q == dim_p1) begin
          x_q <= '0;
          y_q <= y_q + DWIDTH'(1);
        end else begin
          x_q <= x_q + DWIDTH'(1);
        end
      end

      unique case ({req_fire, resp_push})
        2'b10:   outst_q <= outst_q + CntW'(1);
        2'b01:   outst_q <= outst_q - CntW'(1);
        default: ;
      endcase

      if (resp_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({resp_push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: ;
      endcase

      pe_weight_data_valid <= w_pop;
      if (w_pop) pe_weight_data_o <= fifo_mem[rd_ptr_q];
      pe_fm_data_valid <= fm_pop;
      if (fm_pop) pe_fm_data_o <= fifo_mem[rd_ptr_q];
    end
  end

endmodule
